// File: rtl/xadac_vrf_sb.sv
// xadac_vrf_sb: vector-register scoreboard + one-entry issue slice ahead of the VRF read stage.
// Define XADAC_VRF_SB_BYPASS_EN to let a same-cycle retire unblock the incoming request.
module xadac_vrf_sb #(
  parameter int NoVs = 3,
  parameter int NoVregs = 32,
  parameter int MaxOut = 4,
  parameter int PayloadW = 128,
  localparam int AW = $clog2(NoVregs),
  localparam int CW = $clog2(MaxOut + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_req_valid,
  output logic                s_req_ready,
  input  logic [PayloadW-1:0] s_req_payload,
  input  logic [NoVs*AW-1:0]  s_req_vs_addr,
  input  logic [NoVs-1:0]     s_req_vs_read,
  input  logic [AW-1:0]       s_req_vd_addr,
  input  logic                s_req_vd_write,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [PayloadW-1:0] m_req_payload,
  output logic [NoVs*AW-1:0]  m_req_vs_addr,
  input  logic                rsp_valid,
  input  logic                rsp_ready,
  input  logic [AW-1:0]       rsp_vd_addr,
  input  logic                rsp_vd_write,
  output logic [NoVregs-1:0]  busy,
  output logic [CW-1:0]       out_cnt,
  output logic                err
);
  logic retire, dec, raw, waw, acc, bad;
  logic [NoVregs-1:0] clr, set, chk_busy;
  logic [CW-1:0] chk_cnt;
  always_comb begin
    retire = rsp_valid && rsp_ready;
    clr = (retire && rsp_vd_write) ? NoVregs'(1) << rsp_vd_addr : '0;
    dec = retire && (out_cnt != '0);
    bad = retire && ((out_cnt == '0) || (rsp_vd_write && !busy[rsp_vd_addr]));
`ifdef XADAC_VRF_SB_BYPASS_EN
    chk_busy = busy & ~clr;
    chk_cnt = out_cnt - CW'(dec);
`else
    chk_busy = busy;
    chk_cnt = out_cnt;
`endif
    raw = 1'b0;
    for (int i = 0; i < NoVs; i++)
      raw = raw | (s_req_vs_read[i] && chk_busy[s_req_vs_addr[i*AW +: AW]]);
    waw = s_req_vd_write && chk_busy[s_req_vd_addr];
    s_req_ready = !raw && !waw && (chk_cnt < CW'(MaxOut)) && (!m_req_valid || m_req_ready) && !rst;
    acc = s_req_valid && s_req_ready;
    set = (acc && s_req_vd_write) ? NoVregs'(1) << s_req_vd_addr : '0;
  end
  // Set is applied after clear so a bypassed retire+reissue of one vreg stays busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      out_cnt <= '0;
      m_req_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      busy <= (busy & ~clr) | set;
      out_cnt <= out_cnt + CW'(acc) - CW'(dec);
      if (bad) err <= 1'b1;
      if (acc) begin
        m_req_valid <= 1'b1;
        m_req_payload <= s_req_payload;
        m_req_vs_addr <= s_req_vs_addr;
      end else if (m_req_ready) m_req_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xadac_vrf_sb.sv
// tb_xadac_vrf_sb: directed self-checking bench for xadac_vrf_sb in its default build.
module tb_xadac_vrf_sb;
  logic clk = 0, rst = 1;
  logic s_req_valid = 0, s_req_ready;
  logic [127:0] s_req_payload = '0, m_req_payload;
  logic [14:0] s_req_vs_addr = '0, m_req_vs_addr;
  logic [2:0] s_req_vs_read = '0;
  logic [4:0] s_req_vd_addr = '0, rsp_vd_addr = '0;
  logic s_req_vd_write = 0, m_req_valid, m_req_ready = 1;
  logic rsp_valid = 0, rsp_ready = 1, rsp_vd_write = 0;
  logic [31:0] busy;
  logic [2:0] out_cnt;
  logic err;
  int checks = 0, errors = 0;

  xadac_vrf_sb dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_payload(s_req_payload),
    .s_req_vs_addr(s_req_vs_addr), .s_req_vs_read(s_req_vs_read),
    .s_req_vd_addr(s_req_vd_addr), .s_req_vd_write(s_req_vd_write),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_payload(m_req_payload),
    .m_req_vs_addr(m_req_vs_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vd_addr(rsp_vd_addr),
    .rsp_vd_write(rsp_vd_write),
    .busy(busy), .out_cnt(out_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [4:0] vd, input logic wr, input logic [14:0] vs,
                     input logic [2:0] rd, input logic [127:0] pl);
    s_req_valid = 1; s_req_vd_addr = vd; s_req_vd_write = wr;
    s_req_vs_addr = vs; s_req_vs_read = rd; s_req_payload = pl;
    #1;
  endtask

  task automatic rsp(input logic [4:0] vd, input logic wr);
    rsp_valid = 1; rsp_vd_addr = vd; rsp_vd_write = wr;
    #1;
  endtask

  initial begin
    tick();
    chk("ready_in_rst", s_req_ready, 0);
    tick();
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_mvalid", m_req_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", s_req_ready, 1);
    // first request writes v5
    req(5, 1, 0, 0, 128'h1111);
    chk("req1_ready", s_req_ready, 1);
    tick();
    s_req_valid = 0;
    chk("req1_mvalid", m_req_valid, 1);
    chk("req1_payload", m_req_payload, 128'h1111);
    chk("req1_busy", busy, 32'h20);
    chk("req1_cnt", out_cnt, 1);
    // RAW on v5
    req(0, 0, 15'd5, 3'b001, 128'h2222);
    chk("raw_stall", s_req_ready, 0);
    tick();
    chk("slice_drained", m_req_valid, 0);
    chk("raw_stall2", s_req_ready, 0);
    rsp(5, 1);
    chk("raw_retire_cycle", s_req_ready, 0);
    tick();
    rsp_valid = 0;
    chk("retire_busy", busy, 0);
    chk("retire_cnt", out_cnt, 0);
    #1;
    chk("raw_unblocked", s_req_ready, 1);
    tick();
    s_req_valid = 0;
    chk("req2_mvalid", m_req_valid, 1);
    chk("req2_payload", m_req_payload, 128'h2222);
    chk("req2_vs", m_req_vs_addr, 15'd5);
    chk("req2_cnt", out_cnt, 1);
    rsp(0, 0);
    tick();
    rsp_valid = 0;
    chk("nowrite_retire_cnt", out_cnt, 0);
    chk("nowrite_retire_err", err, 0);
    // fill to MaxOut
    for (int i = 1; i <= 4; i++) begin
      req(5'(i), 1, 0, 0, 128'(i));
      tick();
    end
    chk("full_cnt", out_cnt, 4);
    chk("full_busy", busy, 32'h1E);
    req(6, 1, 0, 0, 128'h6666);
    chk("space_stall", s_req_ready, 0);
    tick();
    chk("space_stall_cnt", out_cnt, 4);
    rsp(1, 1);
    chk("space_retire_cycle", s_req_ready, 0);
    tick();
    rsp_valid = 0;
    chk("space_retired_cnt", out_cnt, 3);
    #1;
    chk("space_unblocked", s_req_ready, 1);
    tick();
    s_req_valid = 0;
    chk("fifth_cnt", out_cnt, 4);
    chk("fifth_busy", busy, 32'h5C);
    chk("fifth_payload", m_req_payload, 128'h6666);
    for (int i = 0; i < 4; i++) begin
      rsp(5'(i == 3 ? 6 : i + 2), 1);
      tick();
    end
    rsp_valid = 0;
    chk("drain_cnt", out_cnt, 0);
    chk("drain_busy", busy, 0);
    chk("drain_mvalid", m_req_valid, 0);
    // backpressure on the slice
    m_req_ready = 0;
    req(7, 1, 0, 0, 128'hAAAA);
    tick();
    req(8, 1, 0, 0, 128'hBBBB);
    chk("bp_stall", s_req_ready, 0);
    tick();
    chk("bp_hold_payload", m_req_payload, 128'hAAAA);
    chk("bp_hold_valid", m_req_valid, 1);
    chk("bp_cnt", out_cnt, 1);
    m_req_ready = 1;
    #1;
    chk("bp_release_ready", s_req_ready, 1);
    tick();
    s_req_valid = 0;
    chk("b2b_payload", m_req_payload, 128'hBBBB);
    chk("b2b_valid", m_req_valid, 1);
    chk("b2b_cnt", out_cnt, 2);
    chk("b2b_busy", busy, 32'h180);
    tick();
    chk("b2b_drained", m_req_valid, 0);
    // protocol errors
    rsp(9, 1);
    tick();
    chk("err_nonbusy", err, 1);
    chk("err_nonbusy_busy", busy, 32'h180);
    rsp(7, 1);
    tick();
    rsp(8, 1);
    tick();
    chk("err_sticky", err, 1);
    chk("err_cnt0", out_cnt, 0);
    rsp(0, 0);
    tick();
    rsp_valid = 0;
    chk("underflow_cnt", out_cnt, 0);
    chk("underflow_err", err, 1);
    // build busy=0xFF with the count held by no-write retires
    for (int i = 0; i < 8; i++) begin
      req(5'(i), 1, 0, 0, 128'(i));
      rsp(0, 0);
      tick();
    end
    rsp_valid = 0;
    chk("pre_rst_busy", busy, 32'hFF);
    chk("pre_rst_cnt", out_cnt, 1);
    m_req_ready = 0;
    req(8, 1, 0, 0, 128'hCCCC);
    tick();
    chk("pre_rst_stall", s_req_ready, 0);
    chk("pre_rst_mvalid", m_req_valid, 1);
    rst = 1;
    s_req_valid = 0;
    tick();
    rst = 0;
    m_req_ready = 1;
    req(8, 1, 0, 0, 128'hCCCC);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", out_cnt, 0);
    chk("mid_rst_mvalid", m_req_valid, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", s_req_ready, 1);
    s_req_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
